// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: recovers serial frames into bytes with done/frame-error strobes.
// Latency: 3 clk to detect a start edge; strobe one clk after the mid-stop-bit tick.
// Backpressure: none; the consumer must take o_data on the o_rx_done cycle.
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int N_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int TW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(N_TICKS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic               rx_meta;
  logic               rx_s;
  state_t             state, state_nxt;
  logic [TW-1:0]      tick_cnt, tick_nxt;
  logic [BW-1:0]      bit_cnt, bit_nxt;
  logic [NB_DATA-1:0] sr, sr_nxt;
  logic [NB_DATA-1:0] data_nxt;
  logic               done_nxt;
  logic               err_nxt;

  // Two-flop synchronizer; resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_cnt     <= bit_nxt;
      sr          <= sr_nxt;
      o_data      <= data_nxt;
      o_rx_done   <= done_nxt;
      o_frame_err <= err_nxt;
    end
  end

  // Frame sequencing: start detection is level-based in IDLE, everything else advances only on i_tick.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    data_nxt  = o_data;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_cnt == HALF_LAST) begin
            // Mid start bit: a line already back high was only a glitch.
            if (!rx_s) begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt = '0;
            sr_nxt   = {rx_s, sr[NB_DATA-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (tick_cnt == FULL_LAST) begin
            // Leave at mid stop bit so a start edge right after the stop bit is caught.
            state_nxt = IDLE;
            tick_nxt  = '0;
            if (rx_s) begin
              data_nxt = sr;
              done_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level expectation queue.
// Latency and spacing of strobes are checked against bit-period arithmetic.
// The receiver has no backpressure; the bench consumes every strobe as it occurs.
module tb_uart_rx;

  localparam int NB_DATA = 8;
  localparam int N_TICKS = 16;

  logic               clk;
  logic               i_reset;
  logic               i_rx;
  logic               i_tick;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_period = 1;
  int done_cyc = -1;

  // Expected frame outcomes in order: {is_frame_error, byte}.
  logic [NB_DATA:0]   exp_q[$];
  logic [NB_DATA-1:0] model_data = '0;

  uart_rx #(.NB_DATA(NB_DATA), .N_TICKS(N_TICKS)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_rx       (i_rx),
    .i_tick     (i_tick),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Cycle counter: equals N right after the N-th rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Baud tick generator: one pulse every tick_period clocks (1 = tied high).
  initial begin
    int div;
    div = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period <= 1) begin
        i_tick = 1'b1;
      end else begin
        div = (div + 1) % tick_period;
        i_tick = (div == 0);
      end
    end
  end

  // Strobe monitor: every strobe must match the next expected frame outcome.
  initial begin
    logic [NB_DATA:0] e;
    forever begin
      @(negedge clk);
      if (!i_reset && (o_rx_done || o_frame_err)) begin
        chk("strobe_excl", {31'd0, o_rx_done & o_frame_err}, 32'd0);
        chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, o_frame_err}, {31'd0, e[NB_DATA]});
          if (!e[NB_DATA]) model_data = e[NB_DATA-1:0];
          chk("strobe_data", 32'(o_data), 32'(model_data));
          done_cyc = cyc;
        end
      end
    end
  end

  // Wait for n baud ticks as seen by the DUT, then step just past the edge.
  task automatic wait_ticks(input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      do begin
        @(posedge clk);
        budget++;
      end while (!i_tick && budget < 1000);
      if (!i_tick) chk("tick_timeout", {31'd0, i_tick}, 32'd1);
    end
    #1;
  endtask

  // Drive one 8N1 frame; a bad stop bit is held low past its sample point then released.
  task automatic send_frame(input logic [NB_DATA-1:0] b, input bit stop_ok, output int t0);
    int low_t;
    exp_q.push_back({~stop_ok, b});
    t0 = cyc;
    i_rx = 1'b0;
    wait_ticks(N_TICKS);
    for (int k = 0; k < NB_DATA; k++) begin
      i_rx = b[k];
      wait_ticks(N_TICKS);
    end
    if (stop_ok) begin
      i_rx = 1'b1;
      wait_ticks(N_TICKS);
    end else begin
      low_t = N_TICKS / 2 + N_TICKS / 4 + 1;
      i_rx = 1'b0;
      wait_ticks(low_t);
      i_rx = 1'b1;
      wait_ticks(2 * N_TICKS - low_t);
    end
  endtask

  task automatic frame_end(input string tag);
    chk({tag, "_missing"}, exp_q.size(), 32'd0);
    chk({tag, "_hold"}, 32'(o_data), 32'(model_data));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation ran past cycle budget at cycle %0d", cyc);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d1;
    int gap;
    logic [NB_DATA-1:0] b;
    bit ok;
    i_reset = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_done", {31'd0, o_rx_done}, 32'd0);
    chk("reset_err", {31'd0, o_frame_err}, 32'd0);
    i_reset = 1'b0;
    tick_period = 1;
    wait_ticks(4);

    // Single frame with tick tied high; strobe follows sync + start + data + half stop.
    send_frame(8'hA5, 1'b1, t0);
    frame_end("a5");
    chk("a5_latency", done_cyc - t0, 3 + N_TICKS / 2 + (NB_DATA + 1) * N_TICKS);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, t0);
    frame_end("b2b_00");
    d1 = done_cyc;
    send_frame(8'hFF, 1'b1, t0);
    frame_end("b2b_ff");
    chk("b2b_spacing", done_cyc - d1, (NB_DATA + 2) * N_TICKS);

    // Start glitch: low for 4 ticks only, then a real frame.
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    wait_ticks(N_TICKS);
    frame_end("glitch");
    send_frame(8'h3C, 1'b1, t0);
    frame_end("f3c");

    // Frame error keeps the previously received byte.
    send_frame(8'h11, 1'b1, t0);
    frame_end("f11");
    send_frame(8'h5A, 1'b0, t0);
    frame_end("f5a_err");
    chk("err_keeps_11", 32'(o_data), 32'h11);

    // Reset in the middle of data bit 4 abandons the frame silently.
    b = 8'h6B;
    i_rx = 1'b0;
    wait_ticks(N_TICKS);
    for (int k = 0; k < 4; k++) begin
      i_rx = b[k];
      wait_ticks(N_TICKS);
    end
    i_rx = b[4];
    wait_ticks(N_TICKS / 2);
    i_reset = 1'b1;
    i_rx = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data", 32'(o_data), 32'd0);
    chk("midrst_done", {31'd0, o_rx_done}, 32'd0);
    chk("midrst_err", {31'd0, o_frame_err}, 32'd0);
    i_reset = 1'b0;
    model_data = '0;
    wait_ticks(2 * N_TICKS);
    frame_end("midrst");
    send_frame(8'hC3, 1'b1, t0);
    frame_end("fc3");

    // Randomized frames, tick rates, gaps and stop-bit errors.
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0: tick_period = 1;
        1: tick_period = 2;
        2: tick_period = 3;
        default: tick_period = 5;
      endcase
      b = NB_DATA'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 20);
      if (gap > 0) wait_ticks(gap);
      send_frame(b, ok, t0);
      frame_end("rand");
    end

    // Sparse ticks: counters must hold between pulses.
    tick_period = 326;
    wait_ticks(2);
    send_frame(8'h81, 1'b1, t0);
    frame_end("slow81");
    chk("slow_data", 32'(o_data), 32'h81);

    wait_ticks(4);
    chk("final_pending", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
